// File: rtl/calc_seq_if.sv
// Host and calculator-side signal bundle for calc_sequencer.
// master: the sequencer; slave: the host/calculator side.
interface calc_seq_if;
    localparam int unsigned INSTR_W = 26;

    logic               In_valid;
    logic               In_ready;
    logic [INSTR_W-1:0] In_instr;
    logic               WEN;
    logic [2:0]         RW;
    logic [2:0]         RX;
    logic [2:0]         RY;
    logic [7:0]         DataIn;
    logic               Sel;
    logic [3:0]         Ctrl;
    logic [7:0]         busY;
    logic               Carry;
    logic               Res_valid;
    logic               Res_ready;
    logic [7:0]         Res_data;
    logic               Res_carry;

    modport master (
        input  In_valid, In_instr, busY, Carry, Res_ready,
        output In_ready, WEN, RW, RX, RY, DataIn, Sel, Ctrl,
               Res_valid, Res_data, Res_carry
    );

    modport slave (
        output In_valid, In_instr, busY, Carry, Res_ready,
        input  In_ready, WEN, RW, RX, RY, DataIn, Sel, Ctrl,
               Res_valid, Res_data, Res_carry
    );
endinterface

// File: rtl/calc_sequencer.sv
// Instruction sequencer for simple_calculator: FIFO-buffered instructions, repeated issue, register readback.
// Optional macro CALC_SEQ_STICKY_CARRY_EN: result carry is the OR over all issue cycles instead of the last one.
module calc_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic      Clk,
    input  logic      Rst_n,
    calc_seq_if.master bus,
    output logic      Busy
);
    localparam int unsigned INSTR_W = 26;
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned PW      = AW + 1;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       sel;
        logic       wen;
        logic [2:0] rw;
        logic [2:0] rx;
        logic [2:0] ry;
        logic [2:0] rep;
        logic [7:0] imm;
    } instr_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        READBACK = 2'd2
    } state_t;

    state_t               state_q, state_d;
    instr_t               fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [INSTR_W-1:0]   in_word;
    instr_t               instr_q;
    logic [2:0]           cnt_q;
    logic                 carry_q;
    logic                 carry_s;
    logic                 full, empty, push, pop;

    assign in_word = bus.In_instr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push    = bus.In_valid && !full;
    assign bus.In_ready = !full;
    assign Busy    = (state_q != IDLE) || !empty;

    // Carry is only defined for add/sub; other ops contribute 0.
    assign carry_s = (instr_q.ctrl[3:1] == 3'b000) && bus.Carry;

    // FIFO storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= instr_t'(in_word);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode; everything idles at 0 outside ISSUE/READBACK.
    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        bus.WEN       = 1'b0;
        bus.RW        = 3'd0;
        bus.RX        = 3'd0;
        bus.RY        = 3'd0;
        bus.DataIn    = 8'd0;
        bus.Sel       = 1'b0;
        bus.Ctrl      = 4'd0;
        bus.Res_valid = 1'b0;
        bus.Res_data  = 8'd0;
        bus.Res_carry = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                bus.WEN    = instr_q.wen;
                bus.RW     = instr_q.rw;
                bus.RX     = instr_q.rx;
                bus.RY     = instr_q.ry;
                bus.DataIn = instr_q.imm;
                bus.Sel    = instr_q.sel;
                bus.Ctrl   = instr_q.ctrl;
                if (cnt_q == 3'd0) state_d = READBACK;
            end
            READBACK: begin
                bus.RY        = instr_q.rw;
                bus.Res_valid = 1'b1;
                bus.Res_data  = bus.busY;
                bus.Res_carry = carry_q;
                if (bus.Res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            instr_q <= '0;
            cnt_q   <= 3'd0;
            carry_q <= 1'b0;
        end else if (pop) begin
            instr_q <= fifo_mem[rd_ptr[AW-1:0]];
            cnt_q   <= fifo_mem[rd_ptr[AW-1:0]].rep;
            carry_q <= 1'b0;
        end else if (state_q == ISSUE) begin
            if (cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
`ifdef CALC_SEQ_STICKY_CARRY_EN
            carry_q <= carry_q | carry_s;
`else
            carry_q <= carry_s;
`endif
        end
    end
endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer with a behavioural simple_calculator model.
module tb_calc_sequencer;
    logic Clk;
    logic Rst_n;
    logic Busy;

    calc_seq_if bus();

    calc_sequencer #(.FIFO_DEPTH(4)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus.master),
        .Busy  (Busy)
    );

`ifdef CALC_SEQ_STICKY_CARRY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Calculator model: 8x8 regfile (R0 reads 0), mux, ALU; carry is junk (1) for non add/sub ops.
    logic [7:0] regs [8] = '{default: 8'h00};
    logic [7:0] bus_x, op_a, alu_r;
    logic       alu_c;
    always_comb begin
        bus_x    = regs[bus.RX];
        bus.busY = regs[bus.RY];
        op_a     = bus.Sel ? bus_x : bus.DataIn;
        alu_r    = 8'h00;
        alu_c    = 1'b1;
        case (bus.Ctrl)
            4'b0000: {alu_c, alu_r} = 9'(op_a) + 9'(bus.busY);
            4'b0001: {alu_c, alu_r} = 9'(op_a) - 9'(bus.busY);
            4'b0101: alu_r = op_a | bus.busY;
            default: alu_r = op_a & bus.busY;
        endcase
        bus.Carry = alu_c;
    end
    always @(posedge Clk) begin
        if (bus.WEN && bus.RW != 3'd0) regs[bus.RW] <= alu_r;
    end

    typedef struct packed {
        logic [3:0] ctrl;
        logic       sel;
        logic       wen;
        logic [2:0] rw;
        logic [2:0] rx;
        logic [2:0] ry;
        logic [2:0] rep;
        logic [7:0] imm;
        logic [7:0] exp_data;
        logic       exp_carry;
        logic [3:0] exp_wen;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [25:0] pack(input vec_t v);
        return {v.ctrl, v.sel, v.wen, v.rw, v.rx, v.ry, v.rep, v.imm};
    endfunction

    task automatic push_instr(input logic [25:0] instr);
        @(negedge Clk);
        bus.In_valid = 1'b1;
        bus.In_instr = instr;
        @(posedge Clk);
        #1;
        bus.In_valid = 1'b0;
    endtask

    // Push one instruction into an idle sequencer, then check latency, WEN count and result.
    task automatic run_vec(input vec_t v, input string name);
        int  k;
        int  wens;
        bit  got;
        @(negedge Clk);
        check({name, "_in_ready"}, 32'(bus.In_ready), 32'd1);
        push_instr(pack(v));
        k = 0; wens = 0; got = 1'b0;
        while (!got && k < 40) begin
            @(posedge Clk);
            #1;
            k++;
            if (bus.Res_valid) got = 1'b1;
            else if (bus.WEN) wens++;
        end
        if (!got) begin
            check({name, "_timeout"}, 32'(got), 32'd1);
        end else begin
            check({name, "_latency"}, 32'(k), 32'(v.rep) + 32'd2);
            check({name, "_wen_cycles"}, 32'(wens), 32'(v.exp_wen));
            check({name, "_data"}, 32'(bus.Res_data), 32'(v.exp_data));
            check({name, "_carry"}, 32'(bus.Res_carry), 32'(v.exp_carry));
            check({name, "_ry"}, 32'(bus.RY), 32'(v.rw));
        end
        bus.Res_ready = 1'b1;
        @(posedge Clk);
        #1;
        bus.Res_ready = 1'b0;
        check({name, "_valid_drop"}, 32'(bus.Res_valid), 32'd0);
    endtask

    vec_t vecs [11];
    vec_t v;

    initial begin
        // ctrl sel wen rw rx ry rep imm | data carry wen_cycles
        vecs[0]  = '{4'h0, 1'b0, 1'b1, 3'd1, 3'd0, 3'd0, 3'd0, 8'h05, 8'h05, 1'b0,   4'd1};
        vecs[1]  = '{4'h0, 1'b0, 1'b1, 3'd1, 3'd0, 3'd1, 3'd3, 8'h03, 8'h11, 1'b0,   4'd4};
        vecs[2]  = '{4'h0, 1'b0, 1'b1, 3'd3, 3'd0, 3'd0, 3'd0, 8'h80, 8'h80, 1'b0,   4'd1};
        vecs[3]  = '{4'h0, 1'b0, 1'b1, 3'd3, 3'd0, 3'd3, 3'd0, 8'h80, 8'h00, 1'b1,   4'd1};
        vecs[4]  = '{4'h0, 1'b0, 1'b1, 3'd3, 3'd0, 3'd0, 3'd0, 8'h80, 8'h80, 1'b0,   4'd1};
        vecs[5]  = '{4'h0, 1'b0, 1'b1, 3'd3, 3'd0, 3'd3, 3'd1, 8'h80, 8'h80, STICKY, 4'd2};
        vecs[6]  = '{4'h1, 1'b0, 1'b1, 3'd4, 3'd0, 3'd1, 3'd0, 8'h02, 8'hF1, 1'b1,   4'd1};
        vecs[7]  = '{4'h5, 1'b1, 1'b1, 3'd0, 3'd1, 3'd1, 3'd0, 8'h00, 8'h00, 1'b0,   4'd1};
        vecs[8]  = '{4'h0, 1'b0, 1'b0, 3'd5, 3'd0, 3'd0, 3'd7, 8'h77, 8'h00, 1'b0,   4'd0};
        vecs[9]  = '{4'h0, 1'b1, 1'b1, 3'd6, 3'd1, 3'd4, 3'd0, 8'h00, 8'h02, 1'b1,   4'd1};
        vecs[10] = '{4'h0, 1'b0, 1'b1, 3'd7, 3'd0, 3'd7, 3'd7, 8'h21, 8'h08, 1'b1,   4'd8};

        Rst_n         = 1'b0;
        bus.In_valid  = 1'b0;
        bus.In_instr  = '0;
        bus.Res_ready = 1'b0;
        #12;
        check("rst_in_ready",  32'(bus.In_ready),  32'd1);
        check("rst_wen",       32'(bus.WEN),       32'd0);
        check("rst_res_valid", 32'(bus.Res_valid), 32'd0);
        check("rst_res_data",  32'(bus.Res_data),  32'd0);
        check("rst_busy",      32'(Busy),          32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: five loads with Res_ready low; one sits in the FSM, four fill the FIFO.
        bus.Res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            v = '{4'h0, 1'b0, 1'b1, 3'(i + 1), 3'd0, 3'd0, 3'd0, 8'(8'h11 * (i + 1)), 8'h00, 1'b0, 4'd0};
            @(negedge Clk);
            check($sformatf("bp_in_ready%0d", i), 32'(bus.In_ready), 32'd1);
            push_instr(pack(v));
        end
        check("bp_full", 32'(bus.In_ready), 32'd0);
        @(negedge Clk);
        bus.In_valid = 1'b1;
        bus.In_instr = {4'h0, 1'b0, 1'b1, 3'd6, 3'd0, 3'd0, 3'd0, 8'h99};
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        bus.In_valid = 1'b0;
        check("bp_still_full", 32'(bus.In_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            int k = 0;
            while (!bus.Res_valid && k < 20) begin
                @(posedge Clk);
                #1;
                k++;
            end
            check($sformatf("bp_valid%0d", i), 32'(bus.Res_valid), 32'd1);
            check($sformatf("bp_data%0d", i), 32'(bus.Res_data), 32'(8'h11 * (i + 1)));
            bus.Res_ready = 1'b1;
            @(posedge Clk);
            #1;
            bus.Res_ready = 1'b0;
        end
        repeat (6) @(posedge Clk);
        #1;
        check("bp_no_extra", 32'(bus.Res_valid), 32'd0);
        check("bp_idle", 32'(Busy), 32'd0);

        // Reset during the third cycle of an 8-cycle R2 += 1, with another entry queued.
        run_vec('{4'h0, 1'b0, 1'b1, 3'd2, 3'd0, 3'd0, 3'd0, 8'h10, 8'h10, 1'b0, 4'd1}, "r2_load");
        push_instr({4'h0, 1'b0, 1'b1, 3'd2, 3'd0, 3'd2, 3'd7, 8'h01});
        @(posedge Clk);
        push_instr({4'h0, 1'b0, 1'b1, 3'd6, 3'd0, 3'd0, 3'd0, 8'h66});
        check("mid_wen", 32'(bus.WEN), 32'd1);
        @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        check("mid_rst_wen",       32'(bus.WEN),       32'd0);
        check("mid_rst_busy",      32'(Busy),          32'd0);
        check("mid_rst_res_valid", 32'(bus.Res_valid), 32'd0);
        check("mid_rst_in_ready",  32'(bus.In_ready),  32'd1);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        check("post_rst_busy",  32'(Busy),          32'd0);
        check("post_rst_valid", 32'(bus.Res_valid), 32'd0);
        run_vec('{4'h0, 1'b0, 1'b0, 3'd2, 3'd0, 3'd2, 3'd0, 8'h00, 8'h12, 1'b0, 4'd0}, "r2_read");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
